wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 116 +++++++++++
 tb/tb_wb_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: loads win, then buffered ALU results, then ALU bypass; 1-cycle registered write.
// ALU producer is stalled via alu_ready when the buffer is full; loads are never stalled.
module wb_arbiter #(
   parameter int ALU_DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         alu_valid,
   input  logic [4:0]                   alu_rd,
   input  logic [31:0]                  alu_data,
   output logic                         alu_ready,
   input  logic                         ld_valid,
   input  logic [4:0]                   ld_rd,
   input  logic [31:0]                  ld_data,
   output logic                         ld_ready,
   output logic                         wen,
   output logic [4:0]                   rdest_addr,
   output logic [31:0]                  wdata,
   output logic [31:0]                  pend_mask,
   output logic [$clog2(ALU_DEPTH):0]   alu_count
);

   localparam int PW = $clog2(ALU_DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_ent_t;

   wb_ent_t         ent_q [ALU_DEPTH];
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;

   logic            buf_empty;
   logic            alu_acc;
   logic            bypass;
   logic            push;
   logic            pop;
   logic            sel_vld;
   logic [4:0]      sel_rd;
   logic [31:0]     sel_dat;

   assign ld_ready  = 1'b1;
   // Ready comes from the registered count only, so a same-cycle pop never opens the slot.
   assign alu_ready = (alu_count != CW'(ALU_DEPTH));
   assign buf_empty = (alu_count == '0);
   assign alu_acc   = alu_valid && alu_ready;
   assign pop       = !ld_valid && !buf_empty;
   assign bypass    = !ld_valid && buf_empty && alu_acc;
   assign push      = alu_acc && !bypass;

   always_comb begin
      sel_vld = 1'b0;
      sel_rd  = '0;
      sel_dat = '0;
      if (ld_valid) begin
         sel_vld = 1'b1;
         sel_rd  = ld_rd;
         sel_dat = ld_data;
      end else if (!buf_empty) begin
         sel_vld = 1'b1;
         sel_rd  = ent_q[head].rd;
         sel_dat = ent_q[head].data;
      end else if (bypass) begin
         sel_vld = 1'b1;
         sel_rd  = alu_rd;
         sel_dat = alu_data;
      end
   end

   // Walk the occupied slots from head; pointer arithmetic wraps because depth is a power of two.
   always_comb begin
      pend_mask = '0;
      for (int i = 0; i < ALU_DEPTH; i++) begin
         if (CW'(i) < alu_count) begin
            pend_mask[ent_q[head + PW'(i)].rd] = 1'b1;
         end
      end
      pend_mask[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         ent_q[tail] <= '{rd: alu_rd, data: alu_data};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wen        <= 1'b0;
         rdest_addr <= '0;
         wdata      <= '0;
         head       <= '0;
         tail       <= '0;
         alu_count  <= '0;
      end else begin
         // x0 results are consumed without a register-file write.
         wen        <= sel_vld && (sel_rd != 5'd0);
         rdest_addr <= sel_rd;
         wdata      <= sel_dat;
         if (push) begin
            tail <= tail + PW'(1);
         end
         if (pop) begin
            head <= head + PW'(1);
         end
         unique case ({push, pop})
            2'b10:   alu_count <= alu_count + CW'(1);
            2'b01:   alu_count <= alu_count - CW'(1);
            default: alu_count <= alu_count;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a write scoreboard (separate load and ALU expectation queues).
module tb_wb_arbiter;

   logic        clk;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        alu_ready;
   logic        ld_valid;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic        ld_ready;
   logic        wen;
   logic [4:0]  rdest_addr;
   logic [31:0] wdata;
   logic [31:0] pend_mask;
   logic [1:0]  alu_count;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   exp_t alu_q[$];
   exp_t ld_q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   wb_arbiter #(.ALU_DEPTH(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .alu_valid  (alu_valid),
      .alu_rd     (alu_rd),
      .alu_data   (alu_data),
      .alu_ready  (alu_ready),
      .ld_valid   (ld_valid),
      .ld_rd      (ld_rd),
      .ld_data    (ld_data),
      .ld_ready   (ld_ready),
      .wen        (wen),
      .rdest_addr (rdest_addr),
      .wdata      (wdata),
      .pend_mask  (pend_mask),
      .alu_count  (alu_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic lv, input logic [4:0] lr, input logic [31:0] ldat,
                        input logic av, input logic [4:0] ar, input logic [31:0] adat);
      ld_valid  = lv;
      ld_rd     = lr;
      ld_data   = ldat;
      alu_valid = av;
      alu_rd    = ar;
      alu_data  = adat;
      if (lv && lr != 5'd0) ld_q.push_back('{rd: lr, data: ldat});
   endtask

   // Write monitor: a load presented at an edge must appear right after it; any other write is the next ALU result.
   always @(posedge clk) begin
      logic lp;
      exp_t e;
      lp = ld_valid && (ld_rd != 5'd0) && !rst;
      #2;
      if (lp) begin
         chk("ld_wen", 64'(wen), 64'd1);
         if (ld_q.size() != 0) begin
            e = ld_q.pop_front();
            chk("ld_rd", 64'(rdest_addr), 64'(e.rd));
            chk("ld_data", 64'(wdata), 64'(e.data));
         end
      end else if (wen === 1'b1) begin
         if (alu_q.size() == 0) begin
            chk("stray_wen", 64'(wen), 64'd0);
         end else begin
            e = alu_q.pop_front();
            chk("alu_rd", 64'(rdest_addr), 64'(e.rd));
            chk("alu_data", 64'(wdata), 64'(e.data));
         end
      end
   end

   initial begin
      rst = 1'b1;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      #2;
      chk("rst_wen", 64'(wen), 64'd0);
      chk("rst_addr", 64'(rdest_addr), 64'd0);
      chk("rst_wdata", 64'(wdata), 64'd0);
      chk("rst_count", 64'(alu_count), 64'd0);
      chk("rst_mask", 64'(pend_mask), 64'd0);
      chk("rst_alu_ready", 64'(alu_ready), 64'd1);
      chk("rst_ld_ready", 64'(ld_ready), 64'd1);
      tick();
      rst = 1'b0;

      // Bypass on the very first cycle after reset release.
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hA5A5_A5A5);
      alu_q.push_back('{rd: 5'd5, data: 32'hA5A5_A5A5});
      tick();
      chk("byp_wen", 64'(wen), 64'd1);
      chk("byp_addr", 64'(rdest_addr), 64'd5);
      chk("byp_wdata", 64'(wdata), 64'hA5A5_A5A5);
      chk("byp_count", 64'(alu_count), 64'd0);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();

      // Load and ALU together: load first, ALU parked for one cycle.
      drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
      alu_q.push_back('{rd: 5'd4, data: 32'h22});
      tick();
      chk("col_count1", 64'(alu_count), 64'd1);
      chk("col_mask1", 64'(pend_mask), 64'h10);
      chk("col_addr1", 64'(rdest_addr), 64'd3);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
      chk("col_addr2", 64'(rdest_addr), 64'd4);
      chk("col_wdata2", 64'(wdata), 64'h22);
      chk("col_mask2", 64'(pend_mask), 64'd0);
      chk("col_count2", 64'(alu_count), 64'd0);
      tick();

      // Four back-to-back loads fill the buffer; rd=3 is held until a slot frees.
      drive(1'b1, 5'd10, 32'h100, 1'b1, 5'd1, 32'h1001);
      alu_q.push_back('{rd: 5'd1, data: 32'h1001});
      tick();
      drive(1'b1, 5'd11, 32'h101, 1'b1, 5'd2, 32'h1002);
      alu_q.push_back('{rd: 5'd2, data: 32'h1002});
      tick();
      chk("full_count", 64'(alu_count), 64'd2);
      chk("full_ready", 64'(alu_ready), 64'd0);
      drive(1'b1, 5'd12, 32'h102, 1'b1, 5'd3, 32'h1003);
      alu_q.push_back('{rd: 5'd3, data: 32'h1003});
      tick();
      chk("full_hold_count", 64'(alu_count), 64'd2);
      chk("full_mask", 64'(pend_mask), 64'h6);
      drive(1'b1, 5'd13, 32'h103, 1'b1, 5'd3, 32'h1003);
      tick();
      chk("full_hold_ready", 64'(alu_ready), 64'd0);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h1003);
      tick();
      chk("drain_count1", 64'(alu_count), 64'd1);
      chk("drain_ready", 64'(alu_ready), 64'd1);
      tick();
      chk("pushpop_count", 64'(alu_count), 64'd1);
      chk("pushpop_mask", 64'(pend_mask), 64'h8);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
      chk("drain_count0", 64'(alu_count), 64'd0);
      tick();

      // Writes to x0 are swallowed.
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
      tick();
      chk("x0_wen", 64'(wen), 64'd0);
      chk("x0_count", 64'(alu_count), 64'd0);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();

      // Buffer two entries behind loads, then pulse reset inside a cycle.
      drive(1'b1, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77);
      tick();
      drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd8, 32'h88);
      tick();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      chk("mid_count", 64'(alu_count), 64'd2);
      chk("mid_mask", 64'(pend_mask), 64'h180);
      #3;
      rst = 1'b1;
      alu_q.delete();
      #1;
      chk("arst_wen", 64'(wen), 64'd0);
      chk("arst_addr", 64'(rdest_addr), 64'd0);
      chk("arst_wdata", 64'(wdata), 64'd0);
      chk("arst_count", 64'(alu_count), 64'd0);
      chk("arst_mask", 64'(pend_mask), 64'd0);
      chk("arst_ready", 64'(alu_ready), 64'd1);
      #3;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("post_rst_wen", 64'(wen), 64'd0);
         chk("post_rst_count", 64'(alu_count), 64'd0);
      end
      tick();

      chk("alu_q_drained", 64'(alu_q.size()), 64'd0);
      chk("ld_q_drained", 64'(ld_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
